cell_row_loader: RTL and testbench



---
 rtl/cell_row_loader.sv | 157 +++++++++++++++
 tb/tb_cell_row_loader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_row_loader.sv
// Avalon-MM loader for one logic cell row: stages RAM truth tables and Linux inputs.
// Build option CELL_ROW_LOADER_READBACK_EN makes staging and shadow words readable.
module cell_row_loader #(
    parameter int unsigned DIMX       = 64,
    parameter int unsigned PORT_WIDTH = 32,
    parameter int unsigned SLOTS      = DIMX * 4 / PORT_WIDTH,
    parameter int unsigned LIN_WORDS  = DIMX / PORT_WIDTH,
    parameter int unsigned WE_HOLD    = 2,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic                  avs_write,
    input  logic [PORT_WIDTH-1:0] avs_writedata,
    input  logic                  avs_read,
    output logic [PORT_WIDTH-1:0] avs_readdata,
    output logic                  avs_waitrequest,
    output logic [DIMX*4-1:0]     set_ram,
    output logic [SLOTS-1:0]      we_ram,
    output logic [DIMX-1:0]       out_linux,
    output logic                  busy,
    output logic                  done_irq
);

    localparam int unsigned HW = (WE_HOLD > 1) ? $clog2(WE_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(WE_HOLD - 1);
    localparam logic [ADDR_W-1:0] SLOTS_A = ADDR_W'(SLOTS);
    localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(SLOTS + LIN_WORDS);

    typedef enum logic [1:0] {StIdle, StLoad, StFin} state_e;

    state_e                  state_q, state_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic [SLOTS-1:0]        we_ram_q, we_ram_d;
    logic                    busy_q, irq_q, irq_d, done_q;
    logic [DIMX*4-1:0]       set_ram_q;
    logic [DIMX-1:0]         out_linux_q;
    logic [PORT_WIDTH-1:0]   readdata_q, rdata;
    logic [PORT_WIDTH-1:0]   staging_q [SLOTS];
    logic [PORT_WIDTH-1:0]   shadow_q [LIN_WORDS];

    logic stage_hit, stage_wr, ctrl_wr, start;

    assign stage_hit = avs_write && (avs_address < SLOTS_A);
    assign stage_wr  = stage_hit && !busy_q;
    assign ctrl_wr   = avs_write && (avs_address == CTRL_A);
    assign start     = ctrl_wr && avs_writedata[0] && (state_q == StIdle);

    // Staging writes stall while a commit reads them; everything else is accepted at once.
    assign avs_waitrequest = stage_hit && busy_q;

    assign avs_readdata = readdata_q;
    assign set_ram      = set_ram_q;
    assign we_ram       = we_ram_q;
    assign out_linux    = out_linux_q;
    assign busy         = busy_q;
    assign done_irq     = irq_q;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        we_ram_d = we_ram_q;
        irq_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StLoad;
                    hold_d   = '0;
                    we_ram_d = SLOTS'(1);
                end
            end
            StLoad: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (we_ram_q[SLOTS-1]) begin
                        state_d  = StFin;
                        we_ram_d = '0;
                    end else begin
                        we_ram_d = we_ram_q << 1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
                irq_d   = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            hold_q   <= '0;
            we_ram_q <= '0;
            busy_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            we_ram_q <= we_ram_d;
            busy_q   <= (state_d != StIdle);
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (avs_address == CTRL_A) begin
            rdata = {{(PORT_WIDTH-2){1'b0}}, done_q, busy_q};
        end
`ifdef CELL_ROW_LOADER_READBACK_EN
        for (int unsigned k = 0; k < SLOTS; k++) begin
            if (avs_address == ADDR_W'(k)) rdata = staging_q[k];
        end
        for (int unsigned j = 0; j < LIN_WORDS; j++) begin
            if (avs_address == ADDR_W'(SLOTS + j)) rdata = shadow_q[j];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_ram_q   <= '0;
            out_linux_q <= '0;
            done_q      <= 1'b0;
            readdata_q  <= '0;
            for (int unsigned k = 0; k < SLOTS; k++) staging_q[k] <= '0;
            for (int unsigned j = 0; j < LIN_WORDS; j++) shadow_q[j] <= '0;
        end else begin
            if (start) begin
                for (int unsigned k = 0; k < SLOTS; k++) begin
                    set_ram_q[k*PORT_WIDTH +: PORT_WIDTH] <= staging_q[k];
                end
            end
            if (start || (ctrl_wr && avs_writedata[2])) done_q <= 1'b0;
            // A finishing commit always leaves done set, even against a same-cycle CLR_DONE.
            if (irq_d) done_q <= 1'b1;
            if (ctrl_wr && avs_writedata[1]) begin
                for (int unsigned j = 0; j < LIN_WORDS; j++) begin
                    out_linux_q[j*PORT_WIDTH +: PORT_WIDTH] <= shadow_q[j];
                end
            end
            for (int unsigned k = 0; k < SLOTS; k++) begin
                if (stage_wr && avs_address == ADDR_W'(k)) staging_q[k] <= avs_writedata;
            end
            for (int unsigned j = 0; j < LIN_WORDS; j++) begin
                if (avs_write && avs_address == ADDR_W'(SLOTS + j)) shadow_q[j] <= avs_writedata;
            end
            if (avs_read) readdata_q <= rdata;
        end
    end

endmodule

// File: tb/tb_cell_row_loader.sv
// Self-checking bench for cell_row_loader: vector table, directed commit sequences and
// randomized bus traffic against a cycle-offset reference model.
module tb_cell_row_loader;

    localparam int S = 8;
    localparam int H = 2;
    localparam int LW = 2;
    localparam int CTRL = S + LW;
    localparam int BUSYLEN = S * H + 1;
`ifdef CELL_ROW_LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic         clk, rst;
    logic [7:0]   avs_address;
    logic         avs_write, avs_read;
    logic [31:0]  avs_writedata, avs_readdata;
    logic         avs_waitrequest;
    logic [255:0] set_ram;
    logic [7:0]   we_ram;
    logic [63:0]  out_linux;
    logic         busy, done_irq;

    cell_row_loader dut (
        .clk             (clk),
        .rst             (rst),
        .avs_address     (avs_address),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_read        (avs_read),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .set_ram         (set_ram),
        .we_ram          (we_ram),
        .out_linux       (out_linux),
        .busy            (busy),
        .done_irq        (done_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: storage words plus the edge count at which the last commit began.
    logic [31:0]  m_stage [S];
    logic [31:0]  m_shadow [LW];
    logic [255:0] m_set;
    logic [63:0]  m_lin;
    logic         m_done;
    int           ce = -100000;
    bit           mon_en = 1'b0;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic bit busy_at(input int x);
        int d = x - ce + 1;
        return (d >= 1) && (d <= BUSYLEN);
    endfunction

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] r = '0;
        if (a == CTRL) r = {30'b0, m_done, busy_at(cyc)};
        else if (RB && a < S) r = m_stage[a];
        else if (RB && a < CTRL) r = m_shadow[a-S];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < S; k++) m_stage[k] = '0;
        for (int j = 0; j < LW; j++) m_shadow[j] = '0;
        m_set = '0;
        m_lin = '0;
        m_done = 1'b0;
        ce = -100000;
    endtask

    // Called just after the edge that accepted the write.
    task automatic model_apply(input int a, input logic [31:0] d);
        if (a < S) m_stage[a] = d;
        else if (a < CTRL) m_shadow[a-S] = d;
        else if (a == CTRL) begin
            if (d[1]) for (int j = 0; j < LW; j++) m_lin[j*32 +: 32] = m_shadow[j];
            if (d[2]) m_done = 1'b0;
            if (d[0] && !busy_at(cyc - 1)) begin
                for (int k = 0; k < S; k++) m_set[k*32 +: 32] = m_stage[k];
                m_done = 1'b0;
                ce = cyc;
            end
        end
    endtask

    always @(posedge clk) begin
        int d;
        #2;
        if (rst && mon_en) begin
            d = cyc - ce + 1;
            if (d == BUSYLEN + 1) m_done = 1'b1;
            chk("we_ram", we_ram, (d >= 1 && d <= S * H) ? (256'd1 << ((d - 1) / H)) : 256'd0);
            chk("busy", busy, (d >= 1 && d <= BUSYLEN));
            chk("done_irq", done_irq, (d == BUSYLEN + 1));
            chk("set_ram", set_ram, m_set);
            chk("out_linux", out_linux, m_lin);
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wr(input int a, input logic [31:0] d);
        int n = 0;
        bit go = 1'b1;
        avs_address = 8'(a);
        avs_writedata = d;
        avs_write = 1'b1;
        while (go) begin
            #4;
            chk("waitrequest", avs_waitrequest, (a < S) && busy_at(cyc));
            if (!avs_waitrequest) go = 1'b0;
            else if (n++ > 100) begin
                chk("write_timeout", 1'b1, 1'b0);
                go = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        avs_write = 1'b0;
        model_apply(a, d);
    endtask

    task automatic rd(input int a, output logic [31:0] got, output logic [31:0] exp);
        avs_address = 8'(a);
        avs_read = 1'b1;
        #4;
        exp = model_read(a);
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        got = avs_readdata;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    typedef struct {
        bit          is_rd;
        int          addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] got, exp;
        logic [255:0] exp_set;
        int busy_cnt, c0, n;
        bit irq_seen;

        for (int k = 0; k < S; k++) vecs[k] = '{1'b0, k, 32'h11111111 * (k + 1), 32'h0};
        vecs[8]  = '{1'b1, CTRL, 32'h0, 32'h0};
        vecs[9]  = '{1'b1, 200, 32'h0, 32'h0};
        vecs[10] = '{1'b1, 5, 32'h0, RB ? 32'h66666666 : 32'h0};
        vecs[11] = '{1'b0, 8, 32'hDEADBEEF, 32'h0};
        vecs[12] = '{1'b0, 9, 32'h01234567, 32'h0};
        vecs[13] = '{1'b1, 9, 32'h0, RB ? 32'h01234567 : 32'h0};
        vecs[14] = '{1'b1, 11, 32'h0, 32'h0};
        vecs[15] = '{1'b1, 0, 32'h0, RB ? 32'h11111111 : 32'h0};

        avs_address = '0;
        avs_write = 1'b0;
        avs_read = 1'b0;
        avs_writedata = '0;
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we_ram", we_ram, 0);
        chk("rst_set_ram", set_ram, 0);
        chk("rst_out_linux", out_linux, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_irq", done_irq, 0);
        chk("rst_readdata", avs_readdata, 0);
        rst = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_rd) begin
                rd(vecs[i].addr, got, exp);
                chk($sformatf("vec%0d_read", i), got, vecs[i].exp);
            end else begin
                wr(vecs[i].addr, vecs[i].data);
            end
        end

        // Full commit: slot sequence, busy length and completion pulse.
        for (int k = 0; k < S; k++) exp_set[k*32 +: 32] = 32'h11111111 * (k + 1);
        wr(CTRL, 32'h1);
        busy_cnt = 0;
        irq_seen = 1'b0;
        for (int i = 0; i < 40 && !irq_seen; i++) begin
            if (i <= S * H) chk("commit_we_seq", we_ram, (i < S * H) ? (8'd1 << (i / H)) : 8'd0);
            if (i == 0) chk("commit_set_ram", set_ram, exp_set);
            if (busy) busy_cnt++;
            if (done_irq) irq_seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("commit_busy_len", busy_cnt, 17);
        chk("commit_irq_seen", irq_seen, 1'b1);
        rd(CTRL, got, exp);
        chk("ctrl_done_read", got, 32'h2);

        // Staging write during a commit stalls until the FSM is idle again.
        wr(CTRL, 32'h1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        c0 = cyc;
        wr(0, 32'hA5A5A5A5);
        chk("stall_edges", cyc - c0, 16);
        chk("stall_set_ram_kept", set_ram[31:0], 32'h11111111);
        wait_idle();
        wr(CTRL, 32'h1);
        chk("recommit_word0", set_ram[31:0], 32'hA5A5A5A5);
        wait_idle();

        // APPLY idle and mid-commit.
        chk("lin_before_apply", out_linux, 64'h0);
        wr(CTRL, 32'h2);
        chk("lin_apply", out_linux, 64'h01234567DEADBEEF);
        wr(8, 32'hCAFEF00D);
        wr(9, 32'h76543210);
        chk("lin_unchanged", out_linux, 64'h01234567DEADBEEF);
        wr(CTRL, 32'h1);
        wr(CTRL, 32'h2);
        chk("lin_apply_mid", out_linux, 64'h76543210CAFEF00D);
        chk("lin_apply_busy", busy, 1'b1);
        wait_idle();
        wr(CTRL, 32'h5);
        rd(CTRL, got, exp);
        chk("ctrl_start_clr", got, 32'h1);
        wait_idle();

        // Asynchronous reset in the middle of slot 3.
        wr(CTRL, 32'h1);
        n = 0;
        while (we_ram != 8'h08 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("slot3_reached", we_ram, 8'h08);
        #2;
        rst = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("async_we_ram", we_ram, 0);
        chk("async_busy", busy, 0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_no_irq", done_irq, 0);
        end
        rst = 1'b1;
        mon_en = 1'b1;
        rd(CTRL, got, exp);
        chk("post_rst_ctrl", got, 32'h0);
        chk("post_rst_set_ram", set_ram, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            int a, op;
            logic [31:0] d;
            op = $urandom_range(0, 9);
            a = ($urandom_range(0, 7) == 0) ? $urandom_range(11, 255) : $urandom_range(0, 10);
            d = $urandom;
            if (a == CTRL) d = (d & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
            if (op < 4) begin
                rd(a, got, exp);
                chk("rand_read", got, exp);
            end else if (op < 9) begin
                wr(a, d);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
